// File: rtl/stream_arbiter_rr_pkg.sv
// Shared types and constants for the round-robin stream arbiter.
// Holds the FSM state encoding, default sizes and the channel-index width helper.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int MAX_BURST_DEF  = 8;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_bits_f(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/stream_arbiter_rr_if.sv
// Channel-side and FIFO-side signals of the round-robin arbiter.
// The master modport is the arbiter; the slave modport is the surrounding core.
interface stream_arbiter_rr_if
  import arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic [NUM_CH-1:0]            EN_MASK;
  logic                         THROTTLE;
  logic [NUM_CH-1:0]            REQ;
  logic [NUM_CH-1:0]            HOLD;
  logic [NUM_CH*DATA_WIDTH-1:0] DATA_IN;
  logic [NUM_CH-1:0]            READ_GRANT;
  logic                         ARB_READY_OUT;
  logic                         ARB_WRITE_OUT;
  logic [DATA_WIDTH-1:0]        ARB_DATA_OUT;
  logic                         BUSY;

  modport master (
    input  EN_MASK, THROTTLE, REQ, HOLD, DATA_IN, ARB_READY_OUT,
    output READ_GRANT, ARB_WRITE_OUT, ARB_DATA_OUT, BUSY
  );

  modport slave (
    output EN_MASK, THROTTLE, REQ, HOLD, DATA_IN, ARB_READY_OUT,
    input  READ_GRANT, ARB_WRITE_OUT, ARB_DATA_OUT, BUSY
  );

endinterface

// File: rtl/stream_arbiter_rr_skid_buf.sv
// Two-entry valid/ready output buffer for the arbiter.
// Output valid and data come straight from registers; space lets a full buffer accept on a pop.
module arb_skid_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  out_ready,
  output logic                  space,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  not_empty
);

  logic [1:0]            cnt_r;
  logic [1:0]            cnt_next_s;
  logic                  valid_r;
  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] tail_r;
  logic [DATA_WIDTH-1:0] head_next_s;
  logic [DATA_WIDTH-1:0] tail_next_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  space_s;

  assign pop_s     = valid_r & out_ready;
  assign space_s   = (cnt_r < 2'd2) | pop_s;
  assign push_s    = push_valid & space_s;
  assign space     = space_s;
  assign out_valid = valid_r;
  assign out_data  = head_r;
  assign not_empty = valid_r;

  // Next occupancy and entry contents for every push/pop combination.
  always_comb begin
    cnt_next_s  = cnt_r;
    head_next_s = head_r;
    tail_next_s = tail_r;
    case ({push_s, pop_s})
      2'b10: begin
        case (cnt_r)
          2'd0: begin
            head_next_s = push_data;
            cnt_next_s  = 2'd1;
          end
          2'd1: begin
            tail_next_s = push_data;
            cnt_next_s  = 2'd2;
          end
          default: cnt_next_s = cnt_r;
        endcase
      end
      2'b01: begin
        cnt_next_s = cnt_r - 2'd1;
        if (cnt_r == 2'd2) begin
          head_next_s = tail_r;
        end else begin
          head_next_s = head_r;
        end
      end
      2'b11: begin
        if (cnt_r == 2'd1) begin
          head_next_s = push_data;
        end else if (cnt_r == 2'd2) begin
          head_next_s = tail_r;
          tail_next_s = push_data;
        end else begin
          head_next_s = head_r;
        end
      end
      default: cnt_next_s = cnt_r;
    endcase
  end

  // Buffer registers; reset discards any buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= 2'd0;
      valid_r <= 1'b0;
      head_r  <= '0;
      tail_r  <= '0;
    end else begin
      cnt_r   <= cnt_next_s;
      valid_r <= (cnt_next_s != 2'd0);
      head_r  <= head_next_s;
      tail_r  <= tail_next_s;
    end
  end

endmodule

// File: rtl/stream_arbiter_rr.sv
// Round-robin merger of NUM_CH FWFT streams into one word stream with burst locking,
// per-channel hold, enable mask, optional channel tagging and throttled grant start.
module stream_arbiter_rr
  import arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF,
  parameter int TAG_EN     = 0
) (
  input logic                 BUS_CLK,
  input logic                 BUS_RST,
  stream_arbiter_rr_if.master bus
);

  localparam int CH_BITS = ch_bits_f(NUM_CH);

  arb_state_e            state_r;
  arb_state_e            state_next_s;
  logic [CH_BITS-1:0]    sel_r;
  logic [CH_BITS-1:0]    sel_next_s;
  logic [CH_BITS-1:0]    last_r;
  logic [CH_BITS-1:0]    last_next_s;
  logic [7:0]            burst_cnt_r;
  logic [7:0]            burst_next_s;
  logic [7:0]            burst_inc_s;
  logic [NUM_CH-1:0]     elig_s;
  logic                  pick_found_s;
  logic [CH_BITS-1:0]    pick_idx_s;
  int                    idx_v;
  logic                  sel_ok_s;
  logic                  space_s;
  logic                  grant_s;
  logic [NUM_CH-1:0]     grant_vec_s;
  logic [DATA_WIDTH-1:0] din_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic                  out_valid_s;
  logic [DATA_WIDTH-1:0] out_data_s;
  logic                  not_empty_s;

  assign elig_s      = bus.REQ & bus.EN_MASK;
  assign sel_ok_s    = bus.REQ[sel_r] & bus.EN_MASK[sel_r];
  assign din_s       = bus.DATA_IN[int'(sel_r)*DATA_WIDTH +: DATA_WIDTH];
  assign burst_inc_s = (burst_cnt_r == 8'd255) ? 8'd255 : burst_cnt_r + 8'd1;

  // Rotating scan: walk down from the farthest index so the nearest one after last wins.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    idx_v        = 0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx_v = (int'(last_r) + k) % NUM_CH;
      if (elig_s[idx_v]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = CH_BITS'(idx_v);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // FSM state and arbitration registers.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_r     <= IDLE;
      sel_r       <= '0;
      last_r      <= CH_BITS'(NUM_CH - 1);
      burst_cnt_r <= 8'd0;
    end else begin
      state_r     <= state_next_s;
      sel_r       <= sel_next_s;
      last_r      <= last_next_s;
      burst_cnt_r <= burst_next_s;
    end
  end

  // Next-state: start a lock from IDLE, release it on request loss or burst limit.
  always_comb begin
    state_next_s = state_r;
    sel_next_s   = sel_r;
    last_next_s  = last_r;
    burst_next_s = burst_cnt_r;
    case (state_r)
      IDLE: begin
        if (!bus.THROTTLE && pick_found_s) begin
          state_next_s = LOCK;
          sel_next_s   = pick_idx_s;
          burst_next_s = 8'd0;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOCK: begin
        if (!sel_ok_s) begin
          state_next_s = IDLE;
          last_next_s  = sel_r;
        end else if (grant_s) begin
          burst_next_s = burst_inc_s;
          if ((int'(burst_inc_s) >= MAX_BURST) && !bus.HOLD[sel_r]) begin
            state_next_s = IDLE;
            last_next_s  = sel_r;
          end else begin
            state_next_s = LOCK;
          end
        end else begin
          state_next_s = LOCK;
        end
      end
      default: begin
        state_next_s = IDLE;
        last_next_s  = sel_r;
      end
    endcase
  end

  // Outputs: pop strobe for the locked channel and the (optionally tagged) pushed word.
  always_comb begin
    grant_s     = 1'b0;
    grant_vec_s = '0;
    word_s      = din_s;
    if (!BUS_RST && (state_r == LOCK) && sel_ok_s && space_s) begin
      grant_s            = 1'b1;
      grant_vec_s[sel_r] = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if (TAG_EN != 0) begin
      word_s[DATA_WIDTH-1 -: CH_BITS] = sel_r;
    end else begin
      word_s = din_s;
    end
  end

  arb_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk        (BUS_CLK),
    .rst        (BUS_RST),
    .push_valid (grant_s),
    .push_data  (word_s),
    .out_ready  (bus.ARB_READY_OUT),
    .space      (space_s),
    .out_valid  (out_valid_s),
    .out_data   (out_data_s),
    .not_empty  (not_empty_s)
  );

  assign bus.READ_GRANT    = grant_vec_s;
  assign bus.ARB_WRITE_OUT = out_valid_s;
  assign bus.ARB_DATA_OUT  = out_data_s;
  assign bus.BUSY          = (state_r == LOCK) | not_empty_s;

endmodule
